// File: rtl/seq_shift_add_mult_if.sv
// Operand/handshake/result bundle for the sequential shift-and-add multiplier.
// The master issues operands and start; the slave (the multiplier) returns status and results.
interface seq_shift_add_mult_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
  logic                 bit_out;
  logic                 bit_valid;

  modport master (
    output start, signed_mode, multiplicand, multiplier,
    input  busy, done, product, bit_out, bit_valid
  );

  modport slave (
    input  start, signed_mode, multiplicand, multiplier,
    output busy, done, product, bit_out, bit_valid
  );
endinterface

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-and-add multiplier, one partial product per cycle, signed or unsigned,
// with a start/busy/done handshake and an LSB-first serial product stream.
module seq_shift_add_mult #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  seq_shift_add_mult_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CMAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic signed [WIDTH:0]  a_q, a_d;
  logic [WIDTH-1:0]       q_q, q_d;
  logic [WIDTH-1:0]       x_q, x_d;
  logic                   mode_q, mode_d;
  logic [CW-1:0]          count_q, count_d;
  logic [2*WIDTH-1:0]     product_q, product_d;

  logic signed [WIDTH:0]  xe;
  logic signed [WIDTH:0]  addend;
  logic signed [WIDTH:0]  sum;
  logic                   last_step;
  logic                   fill;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CMAX) ? v : v + CW'(1);
  endfunction

  // Partial-product adder; the final signed step subtracts because the multiplier MSB weighs -2^(W-1)
  always_comb begin
    xe        = mode_q ? $signed({x_q[WIDTH-1], x_q}) : $signed({1'b0, x_q});
    addend    = q_q[0] ? xe : '0;
    last_step = (count_q == LAST);
    sum       = (last_step && mode_q) ? a_q - addend : a_q + addend;
    // Unsigned sums carry out into S[W], so the vacated top bit must be zero, not a sign copy
    fill      = mode_q & sum[WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      q_q       <= '0;
      x_q       <= '0;
      mode_q    <= 1'b0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      x_q       <= x_d;
      mode_q    <= mode_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    x_d       = x_q;
    mode_d    = mode_q;
    count_d   = count_q;
    product_d = product_q;
    if (clr) begin
      state_d   = IDLE;
      a_d       = '0;
      q_d       = '0;
      x_d       = '0;
      mode_d    = 1'b0;
      count_d   = '0;
      product_d = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_d = RUN;
            x_d     = bus.multiplicand;
            mode_d  = bus.signed_mode;
            q_d     = bus.multiplier;
            a_d     = '0;
            count_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          a_d     = $signed({fill, sum[WIDTH:1]});
          q_d     = {sum[0], q_q[WIDTH-1:1]};
          count_d = sat_inc(count_q);
          if (last_step) begin
            state_d   = DONE;
            product_d = {a_d[WIDTH-1:0], q_d};
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.busy      = (state_q == RUN);
    bus.done      = (state_q == DONE);
    bus.bit_valid = (state_q == RUN);
    bus.bit_out   = (state_q == RUN) ? sum[0] : 1'b0;
    bus.product   = product_q;
  end

endmodule
